fpu_mul_arbiter: RTL and testbench
==================================

# fpu_mul_arbiter

Shares one combinational single-precision `Mul` datapath between two requesters. Round-robin arbitration with a valid/ready handshake on each request port. Operands are registered before the multiplier and results after it. The registered result is returned on one valid/ready response port, tagged with the requester ID and carrying the `Mul` overflow and underflow flags. It sits between the FPU issue logic and the multiplier.

## Interface
- `PRIO_RESET`, default 0: requester that wins the first tie after reset (0 or 1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 presents an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  32  IEEE-754 single operands, requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `out_valid`  out  1  response holds a valid result.
- `out_ready`  in  1  consumer takes the response.
- `out_result`  out  32  product, as produced by `Mul`.
- `out_overflow`, `out_underflow`  out  1 each  `Mul` flags for this product.
- `out_id`  out  1  requester that issued this operation.

## Operation
- FSM states:
  - IDLE: accepts one request.
  - CALC: operands are latched and `Mul` settles.
  - HOLD: response is presented.
- IDLE:
  - Grant:
    - Only one valid: that requester is granted.
    - Both valid: the requester not granted last time is granted.
  - The granted requester sees `reqN_ready`=1 combinationally in the same cycle.
  - On that edge, latch `a`, `b` and `id`, update `last_grant`, go to CALC.
  - No valid: stay in IDLE.
- CALC: unconditionally register `Mul` result, overflow, underflow into the output registers. Set `out_valid`=1 and go to HOLD.
- HOLD:
  - `out_valid`=1 and all output fields are stable.
  - `out_ready`=1: clear `out_valid` and go to IDLE on that edge.
  - Otherwise stay (backpressure).
- Ready rules:
  - `reqN_ready` is asserted only in IDLE, only with `reqN_valid`=1, and never to both requesters.
  - Both readies are gated to 0 while `rst`=1.
- Requesters hold valid and operands stable until ready. The block does not check this.
- `last_grant` reset value: `~PRIO_RESET`, so `PRIO_RESET` wins the first tie.
- No flag post-processing: flags and result are passed through exactly as `Mul` produces them.

## Timing
- Reset: state IDLE. `out_valid`, `out_result`, `out_overflow`, `out_underflow`, `out_id` all 0. Both readies 0.
- Latency: request accepted at edge N, `out_valid`=1 after edge N+1.
- Minimum spacing between accepts: 3 cycles (IDLE, CALC, HOLD with `out_ready`=1 throughout).
- No new accept in the cycle `out_ready` retires HOLD. The next accept is earliest in the following IDLE cycle.
- `rst` asserted mid-operation (CALC or HOLD): in-flight operation discarded immediately. No response is produced for it.
- Stalled HOLD: requests are not accepted. Arbitration state is frozen until return to IDLE.
- Combinational path `reqN_valid` → `reqN_ready` is permitted. There is no path from `out_ready` to any request ready.

## Structure
- Shared include `fpu_pkg.vh`:
  - State encodings: IDLE=2'd0, CALC=2'd1, HOLD=2'd2.
  - Width constant `FP_W`=32.
  - Float constants used by benches: ONE=0x3F800000, ONE_P5=0x3FC00000.
- Sub-module `rr_arb2`:
  - Inputs: two valids, enable, `last_grant` update.
  - Outputs: one-hot grant.
  - Holds the round-robin pointer.
- Existing `Mul` is instantiated once, unmodified. Port order: result, overflow, underflow, A, B.
- Top holds the FSM, operand/ID registers and output registers. Target 150–250 lines total.

## Test plan
- Single op: req0 a=0x3F800000, b=0x3FC00000.
  - Required: `req0_ready` in the accept cycle.
  - Two cycles later `out_valid`=1, `out_result`=0x3FC00000, `out_id`=0, flags 0.
- Tie with round-robin, `PRIO_RESET`=0:
  - Both requesters valid continuously. req0 a=b=0x3F800000; req1 a=0xBFA00000, b=0x3FC00000.
  - Required response sequence: id0 0x3F800000, id1 0xBFF00000, id0, id1…
  - Readies never high together.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD.
  - Required: output stable, both readies 0 throughout.
  - Single response on release, next accept one cycle later.
- Flags:
  - 0x7F000000 × 0x40000000 → `out_overflow`=1.
  - 0x00800000 × 0x00800000 → `out_underflow`=1.
- Reset mid-CALC:
  - Assert `rst` asynchronously between edges.
  - Required: all outputs 0 immediately and no response emitted afterwards.
  - Next request after deassert behaves per the single-op case, with requester `PRIO_RESET` winning a tie.

Source files
------------

// File: rtl/fpu_mul_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// State encodings are fixed so waveform viewers and benches agree on them.
package fpu_mul_arbiter_pkg;

   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [FP_W-1:0] ONE    = 32'h3F80_0000;
   localparam logic [FP_W-1:0] ONE_P5 = 32'h3FC0_0000;

endpackage

// File: rtl/fpu_mul_arbiter_mul.sv
// Combinational single-precision multiplier, round-to-nearest-even.
// Subnormal inputs are treated as zero; results that leave the normal range saturate to inf or flush to zero.
module Mul
   import fpu_mul_arbiter_pkg::*;
(
   output logic [FP_W-1:0] result,
   output logic            overflow,
   output logic            underflow,
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b
);

   logic              sign;
   logic [7:0]        ea, eb;
   logic [47:0]       prod, norm;
   logic              guard, sticky, round_up;
   logic [24:0]       rounded;
   logic signed [9:0] exp_sum;
   logic [22:0]       frac;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   always_comb begin
      sign   = a[31] ^ b[31];
      ea     = a[30:23];
      eb     = b[30:23];
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);

      prod     = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      norm     = prod[47] ? prod : {prod[46:0], 1'b0};
      guard    = norm[23];
      sticky   = |norm[22:0];
      round_up = guard & (sticky | norm[24]);
      rounded  = {1'b0, norm[47:24]} + {24'd0, round_up};
      // Mantissa rounding can carry into the exponent, so range checks follow rounding
      exp_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
               + $signed({9'd0, prod[47]}) + $signed({9'd0, rounded[24]});
      frac     = rounded[24] ? rounded[23:1] : rounded[22:0];

      result    = {sign, exp_sum[7:0], frac};
      overflow  = 1'b0;
      underflow = 1'b0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         result = 32'h7FC0_0000;
      else if (a_inf || b_inf)
         result = {sign, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         result = {sign, 31'd0};
      else if (exp_sum >= 10'sd255) begin
         result   = {sign, 8'hFF, 23'd0};
         overflow = 1'b1;
      end
      else if (exp_sum <= 10'sd0) begin
         result    = {sign, 31'd0};
         underflow = 1'b1;
      end
   end

endmodule

// File: rtl/fpu_mul_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot combinational grant.
// The pointer remembers who won last so a tie always goes to the other side.
module rr_arb2 #(
   parameter bit PRIO_RESET = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid0,
   input  logic       valid1,
   input  logic       enable,
   input  logic       update,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid0 && valid1)
            grant = last_grant ? 2'b01 : 2'b10;
         else if (valid0)
            grant = 2'b01;
         else if (valid1)
            grant = 2'b10;
      end
   end

   // Reset points at the other requester so PRIO_RESET wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= ~PRIO_RESET;
      else if (update)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one multiplier between two requesters: round-robin accept, registered
// operands, registered result held on a valid/ready port until taken.
module fpu_mul_arbiter
   import fpu_mul_arbiter_pkg::*;
#(
   parameter bit PRIO_RESET = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [FP_W-1:0] req0_a,
   input  logic [FP_W-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [FP_W-1:0] req1_a,
   input  logic [FP_W-1:0] req1_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [FP_W-1:0] out_result,
   output logic            out_overflow,
   output logic            out_underflow,
   output logic            out_id
);

   state_t          state;
   logic [FP_W-1:0] op_a, op_b;
   logic            op_id;
   logic [1:0]      grant;
   logic            accept;
   logic [FP_W-1:0] mul_result;
   logic            mul_overflow, mul_underflow;

   rr_arb2 #(.PRIO_RESET(PRIO_RESET)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .enable (state == IDLE),
      .update (accept),
      .grant  (grant)
   );

   assign accept     = |grant;
   assign req0_ready = grant[0] & ~rst;
   assign req1_ready = grant[1] & ~rst;

   Mul u_mul (
      .result    (mul_result),
      .overflow  (mul_overflow),
      .underflow (mul_underflow),
      .a         (op_a),
      .b         (op_b)
   );

   // Reset discards any in-flight operation; HOLD blocks new accepts until retired
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         op_a          <= '0;
         op_b          <= '0;
         op_id         <= 1'b0;
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_id        <= 1'b0;
      end
      else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a  <= grant[1] ? req1_a : req0_a;
                  op_b  <= grant[1] ? req1_b : req0_b;
                  op_id <= grant[1];
                  state <= CALC;
               end
            end
            CALC: begin
               out_result    <= mul_result;
               out_overflow  <= mul_overflow;
               out_underflow <= mul_underflow;
               out_id        <= op_id;
               out_valid     <= 1'b1;
               state         <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter: a real-arithmetic multiply model and a
// cycle-level handshake model predict every ready, valid and response.
module tb_fpu_mul_arbiter;
   import fpu_mul_arbiter_pkg::*;

   localparam bit PRIO = 1'b0;

   typedef struct packed { logic [31:0] a; logic [31:0] b; } op_t;
   typedef struct packed { logic [31:0] res; logic ovf; logic unf; logic id; } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        out_valid, out_ready, out_overflow, out_underflow, out_id;
   logic [31:0] out_result;

   int   tests = 0;
   int   fails = 0;
   int   accepts = 0;
   op_t  pend0[$], pend1[$];
   exp_t sb[$];
   logic resp_ids[$], resp_ovf[$], resp_unf[$];
   logic [31:0] resp_res[$];
   bit   inflight = 0;
   int   since = 0;
   bit   model_last = ~PRIO;
   bit   took0, took1, rand_bp = 0;
   logic [1:0] exp_g;

   fpu_mul_arbiter #(.PRIO_RESET(PRIO)) dut (
      .clk           (clk),
      .rst           (rst),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_a        (req0_a),
      .req0_b        (req0_b),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_a        (req1_a),
      .req1_b        (req1_b),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_id        (out_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit id, input logic [31:0] a, input logic [31:0] b);
      if (id) pend1.push_back(op_t'({a, b}));
      else    pend0.push_back(op_t'({a, b}));
   endtask

   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) repeat (n) r = r * 2.0;
      else        repeat (-n) r = r / 2.0;
      return r;
   endfunction

   function automatic real fpValue(input logic [31:0] x);
      return (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
   endfunction

   // Exact product in double precision, then rounded to nearest-even single
   function automatic exp_t refMul(input logic [31:0] a, input logic [31:0] b, input logic id);
      exp_t r;
      real  m, scaled, rem;
      int   e, f;
      logic s;
      s = a[31] ^ b[31];
      m = fpValue(a) * fpValue(b);
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      scaled = (m - 1.0) * 8388608.0;
      f   = $rtoi(scaled);
      rem = scaled - real'(f);
      if (rem > 0.5 || (rem == 0.5 && f[0])) f++;
      if (f == 8388608) begin f = 0; e++; end
      r.id  = id;
      r.ovf = 1'b0;
      r.unf = 1'b0;
      if (e + 127 >= 255) begin
         r.res = {s, 8'hFF, 23'd0};
         r.ovf = 1'b1;
      end
      else if (e + 127 <= 0) begin
         r.res = {s, 31'd0};
         r.unf = 1'b1;
      end
      else
         r.res = {s, 8'(e + 127), 23'(f)};
      return r;
   endfunction

   function automatic logic [31:0] randFp();
      logic [7:0] e;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      e = 8'($urandom_range(1, 20));
      else if (sel == 1) e = 8'($urandom_range(230, 254));
      else               e = 8'($urandom_range(100, 154));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // Requester drivers: hold valid and operands until the ready they saw is taken
   always begin
      @(negedge clk);
      took0 = req0_valid && req0_ready;
      took1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (took0 && pend0.size() > 0) void'(pend0.pop_front());
      if (took1 && pend1.size() > 0) void'(pend1.pop_front());
      if (pend0.size() > 0) begin req0_valid = 1'b1; req0_a = pend0[0].a; req0_b = pend0[0].b; end
      else begin req0_valid = 1'b0; req0_a = '0; req0_b = '0; end
      if (pend1.size() > 0) begin req1_valid = 1'b1; req1_a = pend1[0].a; req1_b = pend1[0].b; end
      else begin req1_valid = 1'b0; req1_a = '0; req1_b = '0; end
   end

   always @(posedge clk) begin
      if (rand_bp) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: one busy operation at a time, result visible from the second edge after accept
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         inflight   = 0;
         since      = 0;
         model_last = ~PRIO;
         checkOutput("ready under reset", 64'({req1_ready, req0_ready}), 64'(0));
         checkOutput("out_valid under reset", 64'(out_valid), 64'(0));
      end
      else begin
         exp_g = 2'b00;
         if (!inflight) begin
            if (req0_valid && req1_valid) exp_g = model_last ? 2'b01 : 2'b10;
            else if (req0_valid)          exp_g = 2'b01;
            else if (req1_valid)          exp_g = 2'b10;
         end
         checkOutput("ready", 64'({req1_ready, req0_ready}), 64'(exp_g));
         checkOutput("out_valid", 64'(out_valid), 64'(inflight && since >= 1));
         if (out_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL spurious response: got result %0h id %0d, expected none", out_result, out_id);
            end
            else
               checkOutput("response", 64'({out_result, out_overflow, out_underflow, out_id}), 64'(sb[0]));
            if (out_ready) begin
               if (sb.size() > 0) void'(sb.pop_front());
               resp_ids.push_back(out_id);
               resp_res.push_back(out_result);
               resp_ovf.push_back(out_overflow);
               resp_unf.push_back(out_underflow);
               inflight = 0;
            end
         end
         if (inflight) since++;
         if (exp_g != 2'b00) begin
            sb.push_back(exp_g[1] ? refMul(req1_a, req1_b, 1'b1) : refMul(req0_a, req0_b, 1'b0));
            accepts++;
            inflight   = 1;
            since      = 0;
            model_last = exp_g[1];
         end
      end
   end

   task automatic clearResp();
      resp_ids.delete();
      resp_res.delete();
      resp_ovf.delete();
      resp_unf.delete();
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while (n < budget && !(pend0.size() == 0 && pend1.size() == 0 && !req0_valid && !req1_valid
                             && sb.size() == 0 && !inflight)) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= budget) begin
         tests++;
         fails++;
         $display("[TB] FAIL timeout: still busy after %0d cycles, expected idle", budget);
      end
   endtask

   initial begin
      int n;
      int base;
      rst = 1'b1;
      out_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

      // Tie traffic is queued under reset so both valids are high while readies must stay low
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, ONE, ONE);
         applyStimulus(1'b1, 32'hBFA0_0000, ONE_P5);
      end
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset out_result", 64'(out_result), 64'(0));
      checkOutput("reset flags+id", 64'({out_overflow, out_underflow, out_id}), 64'(0));
      checkOutput("reset readies with valids", 64'({req1_valid, req0_valid, req1_ready, req0_ready}), 64'(4'b1100));
      rst = 1'b0;
      waitDone(200);
      checkOutput("tie count", 64'(resp_ids.size()), 64'(6));
      for (int i = 0; i < 6; i++) begin
         if (i < resp_ids.size()) begin
            checkOutput("tie id", 64'(resp_ids[i]), 64'(i % 2));
            checkOutput("tie result", 64'(resp_res[i]), 64'((i % 2 == 1) ? 32'hBFF0_0000 : 32'h3F80_0000));
         end
      end

      clearResp();
      applyStimulus(1'b0, ONE, ONE_P5);
      waitDone(50);
      checkOutput("single count", 64'(resp_ids.size()), 64'(1));
      if (resp_ids.size() > 0) begin
         checkOutput("single id", 64'(resp_ids[0]), 64'(0));
         checkOutput("single result", 64'(resp_res[0]), 64'(ONE_P5));
         checkOutput("single flags", 64'({resp_ovf[0], resp_unf[0]}), 64'(0));
      end

      clearResp();
      @(posedge clk); #1;
      out_ready = 1'b0;
      applyStimulus(1'b0, 32'h4000_0000, 32'h4040_0000);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      checkOutput("bp out_valid raised", 64'(out_valid), 64'(1));
      applyStimulus(1'b1, ONE_P5, ONE_P5);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitDone(50);
      checkOutput("bp count", 64'(resp_ids.size()), 64'(2));
      if (resp_ids.size() == 2) begin
         checkOutput("bp first", 64'({resp_ids[0], resp_res[0]}), 64'({1'b0, 32'h40C0_0000}));
         checkOutput("bp second", 64'({resp_ids[1], resp_res[1]}), 64'({1'b1, 32'h4010_0000}));
      end

      clearResp();
      applyStimulus(1'b0, 32'h7F00_0000, 32'h4000_0000);
      waitDone(50);
      applyStimulus(1'b1, 32'h0080_0000, 32'h0080_0000);
      waitDone(50);
      checkOutput("flag count", 64'(resp_ids.size()), 64'(2));
      if (resp_ids.size() == 2) begin
         checkOutput("overflow", 64'({resp_ovf[0], resp_unf[0], resp_res[0]}), 64'({2'b10, 32'h7F80_0000}));
         checkOutput("underflow", 64'({resp_ovf[1], resp_unf[1], resp_res[1]}), 64'({2'b01, 32'h0000_0000}));
      end

      // Leave a nonzero id-1 result on the port, then reset while a requester-0 op is in CALC
      applyStimulus(1'b1, ONE, ONE_P5);
      waitDone(50);
      clearResp();
      base = accepts;
      applyStimulus(1'b0, 32'h4000_0000, 32'h4000_0000);
      n = 0;
      while (accepts == base && n < 20) begin @(negedge clk); #1; n++; end
      checkOutput("midreset accepted", 64'(accepts - base), 64'(1));
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midreset outputs", 64'({out_valid, out_result, out_overflow, out_underflow, out_id}), 64'(0));
      checkOutput("midreset readies", 64'({req1_ready, req0_ready}), 64'(0));
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      applyStimulus(1'b0, ONE, ONE_P5);
      applyStimulus(1'b1, ONE, ONE);
      waitDone(50);
      checkOutput("post-reset count", 64'(resp_ids.size()), 64'(2));
      if (resp_ids.size() == 2) begin
         checkOutput("post-reset first", 64'({resp_ids[0], resp_res[0]}), 64'({1'b0, ONE_P5}));
         checkOutput("post-reset second", 64'({resp_ids[1], resp_res[1]}), 64'({1'b1, ONE}));
      end

      clearResp();
      rand_bp = 1'b1;
      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), randFp(), randFp());
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      end
      waitDone(4000);
      rand_bp = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      checkOutput("random count", 64'(resp_ids.size()), 64'(80));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
